bcd_modn_ctrl: RTL and testbench
================================

# bcd_modn_ctrl

Run/stop controller for a two-digit cascaded BCD (decade) counter chain. It counts 00 up to LIMIT−1, then wraps to 00 and pulses a terminal-count output. It is the sequencing layer above the decade-counter cells: it gates the count enables, handles the tens-digit carry, applies the programmable modulus, and provides start/pause/clear control for timer and clock designs on the lab boards.

## Interface
Parameters:
- ONESHOT, 0: when 1, the counter stops in DONE after the first wrap; when 0, it free-runs.

Ports (clock and reset first):
- CP  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  level, sampled each cycle; start or resume counting.
- STOP  in  1  level, sampled each cycle; pause.
- CLR  in  1  synchronous clear to 00 and return to IDLE.
- TICK  in  1  count qualifier (prescaler strobe); one increment per cycle with TICK=1 in RUN.
- LIMIT_T  in  4  modulus tens digit (BCD).
- LIMIT_U  in  4  modulus units digit (BCD).
- Q_T  out  4  count tens digit.
- Q_U  out  4  count units digit.
- TC  out  1  one-cycle wrap pulse.
- RUNNING  out  1  high while the FSM is in RUN.
- ERR  out  1  sticky flag for an invalid limit at START.
- WRAP_CNT  out  8  number of wraps (present only with BCD_WRAP_CNT_EN).

## Operation
- **States:**
  - IDLE: reset state.
  - RUN.
  - PAUSE.
  - DONE: reachable only when ONESHOT=1.
- **Limit check:** the limit is valid iff both digits are ≤9 and {LIMIT_T,LIMIT_U}≠00. It is latched into shadow registers on an accepted START from IDLE or DONE. Limit changes during RUN or PAUSE are ignored.
- **Priority each cycle:** CLR > STOP > START > TICK.
- **IDLE:**
  - START with a valid limit: latch the limit, clear ERR, go to RUN.
  - START with an invalid limit: set ERR, stay in IDLE.
- **RUN:**
  - STOP: go to PAUSE.
  - TICK otherwise: increment. If Q_U=9, Q_U→0 and Q_T increments.
  - Wrap: if the incremented value equals the latched limit, load 00 and assert TC.
  - With ONESHOT=1, a wrap moves the FSM to DONE.
- **PAUSE:** count holds. START (with STOP low) returns to RUN without re-latching the limit.
- **DONE:** count holds at 00. START re-checks and re-latches the limit, as from IDLE.
- **CLR:** from any state, Q→00, state→IDLE, TC→0, ERR→0, WRAP_CNT→0.
- **Limit 01:** every TICK produces a wrap and a TC pulse; Q stays at 00.
- **Simultaneous START and STOP:** STOP wins; in IDLE or PAUSE the state is unchanged.

## Timing
- **Reset values:** Q_T=0, Q_U=0, TC=0, RUNNING=0, ERR=0, WRAP_CNT=0, state IDLE. Reset is asynchronous and takes effect mid-count with no partial update.
- **Registered outputs:** all outputs are registered, except RUNNING, which is decoded directly from the state register.
- **Count latency:** Q changes on the edge that samples TICK=1 in RUN, so the new value is visible in the following cycle.
- **TC:** high for exactly the one cycle in which Q first shows the wrapped 00.
- **START latency:** START accepted at edge n gives RUNNING=1 after edge n. A TICK sampled at that same edge n is not counted; the first count is at edge n+1.
- **STOP latency:** STOP at edge n freezes Q from edge n onward. A coincident TICK is lost.
- **Back-to-back wraps:** allowed (limit 01 with TICK held high).

## Configuration
- BCD_WRAP_CNT_EN defined: WRAP_CNT port and register exist. The counter increments on every wrap, saturates at 255, and is cleared by RST and CLR.
- BCD_WRAP_CNT_EN undefined: no port and no register; all other behaviour is identical.

## Structure
- **Package bcd_ctrl_pkg:**
  - state enum (IDLE, RUN, PAUSE, DONE).
  - BCD_W=4.
  - BCD_MAX=4'd9.
  - limit-valid function.
- **Sub-module bcd_digit** (instantiated twice):
  - Ports: CP, RST, EN, CLR, LOAD0.
  - Outputs: 4-bit Q and carry CO, where CO = EN & (Q==9).
  - Behaviour: counts 0–9 with wrap.
  - The tens digit EN is the units digit CO.
  - The controller drives LOAD0 on a modulus wrap.

## Test plan
- **Basic count and wrap:** RST, LIMIT=12, START, TICK held high → Q 00..11 on successive cycles, then 00 with TC=1 for one cycle. RUNNING=1 throughout.
- **Decade carry:** LIMIT=25, 9 TICKs → Q=09; one more TICK → Q=10.
- **Pause and resume:** STOP at Q=07 → TICKs ignored and Q holds at 07. START → next TICK gives 08. A limit changed during PAUSE does not alter the wrap point.
- **Invalid limits:** LIMIT=00 or LIMIT_U=A with START → ERR=1, RUNNING=0, Q=00. Then a valid START → ERR=0, RUN.
- **ONESHOT and limit 01:** ONESHOT=1, LIMIT=03 → Q 00,01,02,00, one TC, state DONE, further TICKs ignored. ONESHOT=0, LIMIT=01 → TC high every TICK cycle.
- **CLR, reset and simultaneous controls:** CLR mid-count → Q=00, IDLE, next cycle. RST asserted asynchronously mid-cycle → all outputs 0 immediately. START and STOP together in PAUSE → stays in PAUSE.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_ctrl_pkg
//  Purpose : Shared types and constants for the BCD modulus controller:
//            FSM state encoding, digit width/maximum and the limit check.
//  Rev     : 1.0  initial release
// ============================================================================
package bcd_ctrl_pkg;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A modulus is usable only when both digits are decimal and it is not 00.
  function automatic logic limit_valid(input logic [BCD_W-1:0] t,
                                       input logic [BCD_W-1:0] u);
    return (t <= BCD_MAX) && (u <= BCD_MAX) && ({t, u} != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_modn_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_modn_ctrl_if
//  Purpose : Control/status bundle between a host and bcd_modn_ctrl.
//            WRAP_CNT is present only when BCD_WRAP_CNT_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
interface bcd_modn_ctrl_if;
  import bcd_ctrl_pkg::*;

  logic             START;
  logic             STOP;
  logic             CLR;
  logic             TICK;
  logic [BCD_W-1:0] LIMIT_T;
  logic [BCD_W-1:0] LIMIT_U;
  logic [BCD_W-1:0] Q_T;
  logic [BCD_W-1:0] Q_U;
  logic             TC;
  logic             RUNNING;
  logic             ERR;
`ifdef BCD_WRAP_CNT_EN
  logic [7:0]       WRAP_CNT;

  modport master (output START, STOP, CLR, TICK, LIMIT_T, LIMIT_U,
                  input  Q_T, Q_U, TC, RUNNING, ERR, WRAP_CNT);
  modport slave  (input  START, STOP, CLR, TICK, LIMIT_T, LIMIT_U,
                  output Q_T, Q_U, TC, RUNNING, ERR, WRAP_CNT);
`else
  modport master (output START, STOP, CLR, TICK, LIMIT_T, LIMIT_U,
                  input  Q_T, Q_U, TC, RUNNING, ERR);
  modport slave  (input  START, STOP, CLR, TICK, LIMIT_T, LIMIT_U,
                  output Q_T, Q_U, TC, RUNNING, ERR);
`endif

endinterface
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_digit
//  Purpose : Single decade counter cell, 0..9 with wrap. CLR and LOAD0 both
//            force 0; CO flags that this enabled increment rolls 9 -> 0.
//  Rev     : 1.0  initial release
// ============================================================================
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  wire              CP,
  input  wire              RST,
  input  wire              EN,
  input  wire              CLR,
  input  wire              LOAD0,
  output logic [BCD_W-1:0] Q,
  output logic             CO
);

  logic [BCD_W-1:0] r_q;

  // Decade count with synchronous zero-load taking precedence over counting.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else if (CLR || LOAD0) begin
      r_q <= '0;
    end else if (EN) begin
      r_q <= (r_q == BCD_MAX) ? '0 : r_q + 1'b1;
    end
  end

  assign Q  = r_q;
  assign CO = EN & (r_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_modn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_modn_ctrl
//  Purpose : Run/stop/pause controller for a two-digit BCD counter with a
//            programmable modulus, wrap pulse and optional one-shot mode.
//            Optional wrap counter enabled by defining BCD_WRAP_CNT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module bcd_modn_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int ONESHOT = 0
)
(
  input  wire            CP,
  input  wire            RST,
  bcd_modn_ctrl_if.slave bus
);

  state_t           r_state;
  logic [BCD_W-1:0] r_lim_t;
  logic [BCD_W-1:0] r_lim_u;
  logic             r_tc;
  logic             r_err;

  logic [BCD_W-1:0] w_q_t;
  logic [BCD_W-1:0] w_q_u;
  logic             w_u_co;
  logic             w_t_co;
  logic             w_count;
  logic [BCD_W-1:0] w_nxt_t;
  logic [BCD_W-1:0] w_nxt_u;
  logic             w_wrap;

  // CLR and STOP both outrank a tick, and only RUN ever counts.
  assign w_count = (r_state == ST_RUN) & ~bus.CLR & ~bus.STOP & bus.TICK;

  // Value the chain would show after this increment, used for the limit match.
  assign w_nxt_u = w_u_co ? '0 : w_q_u + 1'b1;
  assign w_nxt_t = w_u_co ? w_q_t + 1'b1 : w_q_t;

  // A tens carry can only occur at 99, which any legal limit already catches;
  // folding it in keeps the chain from silently rolling over without a TC.
  assign w_wrap = w_count & (({w_nxt_t, w_nxt_u} == {r_lim_t, r_lim_u}) | w_t_co);

  bcd_digit u_digit_u (
    .CP    (CP),
    .RST   (RST),
    .EN    (w_count),
    .CLR   (bus.CLR),
    .LOAD0 (w_wrap),
    .Q     (w_q_u),
    .CO    (w_u_co)
  );

  bcd_digit u_digit_t (
    .CP    (CP),
    .RST   (RST),
    .EN    (w_u_co),
    .CLR   (bus.CLR),
    .LOAD0 (w_wrap),
    .Q     (w_q_t),
    .CO    (w_t_co)
  );

  // Control FSM with limit shadowing and registered TC/ERR.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_lim_t <= '0;
      r_lim_u <= '0;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.CLR) begin
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_tc <= w_wrap;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (!bus.STOP && bus.START) begin
            if (limit_valid(bus.LIMIT_T, bus.LIMIT_U)) begin
              r_lim_t <= bus.LIMIT_T;
              r_lim_u <= bus.LIMIT_U;
              r_err   <= 1'b0;
              r_state <= ST_RUN;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.STOP) begin
            r_state <= ST_PAUSE;
          end else if (w_wrap && (ONESHOT != 0)) begin
            r_state <= ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (!bus.STOP && bus.START) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BCD_WRAP_CNT_EN
  logic [7:0] r_wrap_cnt;

  // Saturating count of modulus wraps since the last reset or clear.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_wrap_cnt <= '0;
    end else if (bus.CLR) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap && (r_wrap_cnt != 8'hFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end
  end

  assign bus.WRAP_CNT = r_wrap_cnt;
`endif

  assign bus.Q_T     = w_q_t;
  assign bus.Q_U     = w_q_u;
  assign bus.TC      = r_tc;
  assign bus.ERR     = r_err;
  assign bus.RUNNING = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_bcd_modn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bcd_modn_ctrl
//  Purpose : Bench for bcd_modn_ctrl. Two instances (free-running and
//            one-shot) share stimulus and are checked against a decimal
//            model every cycle. Honours BCD_WRAP_CNT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_bcd_modn_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int st;
    int cnt;
    int lim;
    int tc;
    int err;
    int wc;
  } mdl_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       clr   = 1'b0;
  logic       tick  = 1'b0;
  logic [3:0] lim_t = 4'd0;
  logic [3:0] lim_u = 4'd0;

  int n_chk  = 0;
  int n_fail = 0;

  mdl_t m0;
  mdl_t m1;

  bcd_modn_ctrl_if if0 ();
  bcd_modn_ctrl_if if1 ();

  assign if0.START   = start;
  assign if0.STOP    = stop;
  assign if0.CLR     = clr;
  assign if0.TICK    = tick;
  assign if0.LIMIT_T = lim_t;
  assign if0.LIMIT_U = lim_u;
  assign if1.START   = start;
  assign if1.STOP    = stop;
  assign if1.CLR     = clr;
  assign if1.TICK    = tick;
  assign if1.LIMIT_T = lim_t;
  assign if1.LIMIT_U = lim_u;

  bcd_modn_ctrl #(.ONESHOT(0)) dut0 (.CP(clk), .RST(rst), .bus(if0.slave));
  bcd_modn_ctrl #(.ONESHOT(1)) dut1 (.CP(clk), .RST(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qv(input logic [3:0] t, input logic [3:0] u);
    return int'({t, u});
  endfunction

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.st = M_IDLE; z.cnt = 0; z.lim = 0; z.tc = 0; z.err = 0; z.wc = 0;
    return z;
  endfunction

  // One clock of the controller, expressed on a plain decimal count.
  function automatic mdl_t mdl_step(input mdl_t s, input bit oneshot);
    mdl_t n;
    n = s;
    if (clr) begin
      n.st = M_IDLE; n.cnt = 0; n.tc = 0; n.err = 0; n.wc = 0;
      return n;
    end
    n.tc = 0;
    case (s.st)
      M_IDLE, M_DONE: begin
        if (start && !stop) begin
          if (lim_t <= 4'd9 && lim_u <= 4'd9 && (lim_t != 4'd0 || lim_u != 4'd0)) begin
            n.lim = int'(lim_t) * 10 + int'(lim_u);
            n.err = 0;
            n.st  = M_RUN;
          end else begin
            n.err = 1;
          end
        end
      end
      M_RUN: begin
        if (stop) begin
          n.st = M_PAUSE;
        end else if (tick) begin
          n.cnt = s.cnt + 1;
          if (n.cnt == s.lim) begin
            n.cnt = 0;
            n.tc  = 1;
            if (s.wc < 255) n.wc = s.wc + 1;
            if (oneshot) n.st = M_DONE;
          end
        end
      end
      M_PAUSE: begin
        if (start && !stop) n.st = M_RUN;
      end
      default: ;
    endcase
    return n;
  endfunction

  // Reference model advances on the same edges as the DUTs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= mdl_zero();
      m1 <= mdl_zero();
    end else begin
      m0 <= mdl_step(m0, 1'b0);
      m1 <= mdl_step(m1, 1'b1);
    end
  end

  task automatic cmp(input string tag, input logic [3:0] qt, input logic [3:0] qu,
                     input logic tc, input logic run, input logic err, input mdl_t m);
    chk({tag, ".Q_T"},     int'(qt),  m.cnt / 10);
    chk({tag, ".Q_U"},     int'(qu),  m.cnt % 10);
    chk({tag, ".TC"},      int'(tc),  m.tc);
    chk({tag, ".RUNNING"}, int'(run), int'(m.st == M_RUN));
    chk({tag, ".ERR"},     int'(err), m.err);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      cmp("d0", if0.Q_T, if0.Q_U, if0.TC, if0.RUNNING, if0.ERR, m0);
      cmp("d1", if1.Q_T, if1.Q_U, if1.TC, if1.RUNNING, if1.ERR, m1);
`ifdef BCD_WRAP_CNT_EN
      chk("d0.WRAP_CNT", int'(if0.WRAP_CNT), m0.wc);
      chk("d1.WRAP_CNT", int'(if1.WRAP_CNT), m1.wc);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic go(input logic [3:0] t, input logic [3:0] u);
    lim_t = t; lim_u = u; start = 1'b1; tick = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(2);
    rst = 1'b0;
    chk("rst.Q",       qv(if0.Q_T, if0.Q_U), 'h00);
    chk("rst.TC",      int'(if0.TC), 0);
    chk("rst.RUNNING", int'(if0.RUNNING), 0);
    chk("rst.ERR",     int'(if0.ERR), 0);

    // Basic count and wrap at 12; the TICK coincident with START is not counted
    go(4'd1, 4'd2);
    chk("basic.run",  int'(if0.RUNNING), 1);
    chk("basic.q0",   qv(if0.Q_T, if0.Q_U), 'h00);
    cyc(11);
    chk("basic.q11",  qv(if0.Q_T, if0.Q_U), 'h11);
    chk("basic.tc0",  int'(if0.TC), 0);
    cyc(1);
    chk("basic.wrapq", qv(if0.Q_T, if0.Q_U), 'h00);
    chk("basic.wraptc", int'(if0.TC), 1);
    chk("basic.run2", int'(if0.RUNNING), 1);
    cyc(1);
    chk("basic.tcoff", int'(if0.TC), 0);
    chk("basic.q01",  qv(if0.Q_T, if0.Q_U), 'h01);

    // CLR mid-count
    clr_pulse();
    chk("clr.q",   qv(if0.Q_T, if0.Q_U), 'h00);
    chk("clr.run", int'(if0.RUNNING), 0);

    // Decade carry
    go(4'd2, 4'd5);
    cyc(9);
    chk("carry.q09", qv(if0.Q_T, if0.Q_U), 'h09);
    cyc(1);
    chk("carry.q10", qv(if0.Q_T, if0.Q_U), 'h10);

    // Pause, START+STOP in pause, limit change ignored, resume
    clr_pulse();
    go(4'd1, 4'd2);
    cyc(7);
    chk("pause.q07", qv(if0.Q_T, if0.Q_U), 'h07);
    stop = 1'b1;
    cyc(3);
    chk("pause.hold", qv(if0.Q_T, if0.Q_U), 'h07);
    chk("pause.run",  int'(if0.RUNNING), 0);
    start = 1'b1; lim_t = 4'd0; lim_u = 4'd8;
    cyc(2);
    chk("pause.both", int'(if0.RUNNING), 0);
    stop = 1'b0;
    cyc(1);
    start = 1'b0;
    chk("resume.run", int'(if0.RUNNING), 1);
    chk("resume.q07", qv(if0.Q_T, if0.Q_U), 'h07);
    cyc(1);
    chk("resume.q08", qv(if0.Q_T, if0.Q_U), 'h08);
    cyc(1);
    chk("resume.q09", qv(if0.Q_T, if0.Q_U), 'h09);
    cyc(3);
    chk("resume.wrap", qv(if0.Q_T, if0.Q_U), 'h00);
    chk("resume.tc",   int'(if0.TC), 1);

    // Invalid limits
    clr_pulse();
    go(4'd0, 4'd0);
    chk("inv00.err", int'(if0.ERR), 1);
    chk("inv00.run", int'(if0.RUNNING), 0);
    chk("inv00.q",   qv(if0.Q_T, if0.Q_U), 'h00);
    go(4'd0, 4'hA);
    chk("inv0A.err", int'(if0.ERR), 1);
    chk("inv0A.run", int'(if0.RUNNING), 0);
    go(4'd0, 4'd3);
    chk("valid.err", int'(if0.ERR), 0);
    chk("valid.run", int'(if0.RUNNING), 1);

    // One-shot with limit 03 on the ONESHOT=1 instance
    clr_pulse();
    go(4'd0, 4'd3);
    chk("os.q0", qv(if1.Q_T, if1.Q_U), 'h00);
    cyc(1);
    chk("os.q1", qv(if1.Q_T, if1.Q_U), 'h01);
    cyc(1);
    chk("os.q2", qv(if1.Q_T, if1.Q_U), 'h02);
    cyc(1);
    chk("os.wrapq",  qv(if1.Q_T, if1.Q_U), 'h00);
    chk("os.tc",     int'(if1.TC), 1);
    chk("os.done",   int'(if1.RUNNING), 0);
    cyc(3);
    chk("os.holdq",  qv(if1.Q_T, if1.Q_U), 'h00);
    chk("os.holdtc", int'(if1.TC), 0);

    // Limit 01 free-running: TC every ticked cycle
    clr_pulse();
    go(4'd0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("lim01.tc", int'(if0.TC), 1);
      chk("lim01.q",  qv(if0.Q_T, if0.Q_U), 'h00);
    end
`ifdef BCD_WRAP_CNT_EN
    chk("lim01.wc4", int'(if0.WRAP_CNT), 4);
    cyc(260);
    chk("lim01.wcsat", int'(if0.WRAP_CNT), 255);
`endif

    // Asynchronous reset mid-cycle
    go(4'd2, 4'd0);
    cyc(5);
    #2 rst = 1'b1;
    #1;
    chk("arst.q",   qv(if0.Q_T, if0.Q_U), 'h00);
    chk("arst.run", int'(if0.RUNNING), 0);
    chk("arst.tc",  int'(if0.TC), 0);
    chk("arst.err", int'(if0.ERR), 0);
    chk("arst.q1",  qv(if1.Q_T, if1.Q_U), 'h00);
    cyc(1);
    rst = 1'b0; tick = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      clr   = ($urandom_range(0, 99) < 2);
      stop  = ($urandom_range(0, 99) < 8);
      start = ($urandom_range(0, 99) < 15);
      tick  = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 7) == 0) begin
        lim_t = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11))
                                            : 4'($urandom_range(0, 1));
        lim_u = 4'($urandom_range(0, 11));
      end
    end
    clr = 1'b0; stop = 1'b0; start = 1'b0; tick = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
